// File: rtl/booth_mul_scheduler.sv
// Round-robin front end that shares one signed multiplier between N_REQ clients.
// Serves one job at a time with a watchdog and returns the product tagged with the requester id.
module booth_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]         resp_prod,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       mul_init,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic                       mul_done,
    input  logic [2*WIDTH-1:0]         mul_prod
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LAUNCH = 4'b0010,
        WAIT   = 4'b0100,
        RESP   = 4'b1000
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [ID_W-1:0]   last_r;
    logic [ID_W-1:0]   gid_r;
    logic [ID_W-1:0]   grant_id_s;
    logic              grant_any_s;
    logic [TMR_W-1:0]  timer_r;
    logic              timeout_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic [WIDTH-1:0]  mul_a_r;
    logic [WIDTH-1:0]  mul_b_r;
    logic [ID_W-1:0]   resp_id_r;
    logic [2*WIDTH-1:0] resp_prod_r;
    logic              resp_err_r;

    // Round-robin search: walk from farthest to nearest so the nearest hit after last_r wins.
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = {ID_W{1'b0}};
        for (int off = N_REQ; off >= 1; off--) begin
            int idx;
            idx         = (int'(last_r) + off) % N_REQ;
            grant_any_s = req_valid[idx] ? 1'b1 : grant_any_s;
            grant_id_s  = req_valid[idx] ? ID_W'(idx) : grant_id_s;
        end
    end

    // Accept strobe toward the granted client, only while idle and out of reset.
    always_comb begin
        req_ready_s = {N_REQ{1'b0}};
        if ((state_r == IDLE) && grant_any_s && !rst) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = {N_REQ{1'b0}};
        end
    end

    assign timeout_s = (timer_r == TMR_W'(TIMEOUT - 1));

    // Next-state logic; a completion strobe outranks the watchdog.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_any_s) state_n_s = LAUNCH;
                else             state_n_s = IDLE;
            end
            LAUNCH: state_n_s = WAIT;
            WAIT: begin
                if (mul_done || timeout_s) state_n_s = RESP;
                else                       state_n_s = WAIT;
            end
            RESP:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // State, operand, timer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            last_r      <= ID_W'(N_REQ - 1);
            gid_r       <= {ID_W{1'b0}};
            timer_r     <= {TMR_W{1'b0}};
            mul_a_r     <= {WIDTH{1'b0}};
            mul_b_r     <= {WIDTH{1'b0}};
            resp_id_r   <= {ID_W{1'b0}};
            resp_prod_r <= {(2*WIDTH){1'b0}};
            resp_err_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        gid_r   <= grant_id_s;
                        mul_a_r <= req_a[int'(grant_id_s)*WIDTH +: WIDTH];
                        mul_b_r <= req_b[int'(grant_id_s)*WIDTH +: WIDTH];
                    end
                end
                LAUNCH: timer_r <= {TMR_W{1'b0}};
                WAIT: begin
                    timer_r <= timer_r + TMR_W'(1);
                    if (mul_done) begin
                        resp_prod_r <= mul_prod;
                        resp_err_r  <= 1'b0;
                        resp_id_r   <= gid_r;
                    end else if (timeout_s) begin
                        resp_prod_r <= {(2*WIDTH){1'b0}};
                        resp_err_r  <= 1'b1;
                        resp_id_r   <= gid_r;
                    end
                end
                RESP:    last_r <= gid_r;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign busy       = (state_r != IDLE);
    assign mul_init   = (state_r == LAUNCH);
    assign resp_valid = (state_r == RESP);
    assign resp_id    = resp_id_r;
    assign resp_prod  = resp_prod_r;
    assign resp_err   = resp_err_r;
    assign mul_a      = mul_a_r;
    assign mul_b      = mul_b_r;
endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Directed and random checks of booth_mul_scheduler; the bench plays the multiplier
// and predicts grants, timing and products from a simple arbitration/arithmetic model.
module tb_booth_mul_scheduler;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [2*W-1:0] resp_prod;
    logic           resp_err, busy, mul_init;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_prod;

    int total = 0;
    int bad   = 0;
    int model_last;

    booth_mul_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_prod(resp_prod), .resp_err(resp_err), .busy(busy), .mul_init(mul_init),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_prod(mul_prod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected grant: first requester after the last served one, cyclically.
    function automatic int model_grant();
        for (int d = 1; d <= N; d++) begin
            if (req_valid[(model_last + d) % N]) return (model_last + d) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] one;
        one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rvalid"}, resp_valid, 0);
        chk({tag, "_rid"}, resp_id, 0);
        chk({tag, "_rprod"}, resp_prod, 0);
        chk({tag, "_rerr"}, resp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_init"}, mul_init, 0);
        chk({tag, "_a"}, mul_a, 0);
        chk({tag, "_b"}, mul_b, 0);
    endtask

    // One full job, starting and ending in an idle cycle. The multiplier answers k
    // cycles after mul_init; k > TO means it never answers.
    task automatic do_job(input int k, input bit done_in_launch, output int g);
        logic [W-1:0]   ea, eb;
        logic [2*W-1:0] ep;
        int pa, pb, rc;
        bit terr;
        #1;
        g = model_grant();
        chk("idle_busy", busy, 0);
        chk("grant_ready", req_ready, onehot(g));
        if (g < 0) return;
        ea = req_a[g*W +: W];
        eb = req_b[g*W +: W];
        pa = $signed(ea);
        pb = $signed(eb);
        ep = 16'(pa * pb);
        terr = (k > TO);
        rc = terr ? TO + 1 : k + 1;
        step();
        chk("launch_init", mul_init, 1);
        chk("launch_a", mul_a, ea);
        chk("launch_b", mul_b, eb);
        chk("launch_busy", busy, 1);
        chk("launch_ready", req_ready, 0);
        if (done_in_launch) begin
            mul_done = 1'b1;
            mul_prod = ~ep;
        end
        for (int i = 1; i <= rc; i++) begin
            step();
            mul_done = 1'b0;
            if (i == rc) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_id", resp_id, g);
                chk("resp_prod", resp_prod, terr ? 16'h0 : ep);
                chk("resp_err", resp_err, terr);
                chk("resp_ready", req_ready, 0);
            end else begin
                chk("wait_valid", resp_valid, 0);
                chk("wait_busy", busy, 1);
                chk("wait_ready", req_ready, 0);
                chk("wait_init", mul_init, 0);
                chk("wait_hold_a", mul_a, ea);
                if (i == k) begin
                    mul_done = 1'b1;
                    mul_prod = ep;
                end
            end
        end
        model_last = g;
        step();
        chk("post_valid", resp_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_hold_id", resp_id, g);
        chk("post_hold_err", resp_err, terr);
    endtask

    initial begin
        int g;
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        mul_done = 1'b0;
        mul_prod = '0;
        model_last = N - 1;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // All four requesters held high: strict rotation.
        req_a = $urandom;
        req_b = $urandom;
        req_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            do_job(5, 1'b0, g);
            chk("rr_order", g, exp_order[j]);
        end

        // last = 1: requesters 0 and 2 together, 2 wins, then 0.
        req_valid = 4'b0101;
        do_job(3, 1'b0, g);
        chk("rr_pair_first", g, 2);
        req_valid = 4'b0001;
        do_job(2, 1'b0, g);
        chk("rr_pair_second", g, 0);

        // Single requester 0: 3 * -5.
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'hFB;
        do_job(10, 1'b0, g);
        chk("s1_id", resp_id, 0);
        chk("s1_prod", resp_prod, 16'hFFF1);
        req_valid = '0;

        // Watchdog on requester 1, then requester 2 served normally.
        req_valid = 4'b0010;
        do_job(TO + 10, 1'b0, g);
        chk("to_id", resp_id, 1);
        chk("to_prod", resp_prod, 0);
        chk("to_err", resp_err, 1);
        req_valid = 4'b0100;
        do_job(4, 1'b0, g);
        chk("after_to_id", g, 2);
        chk("after_to_err", resp_err, 0);

        // Strobe while idle is ignored.
        req_valid = '0;
        mul_done = 1'b1;
        mul_prod = 16'h1234;
        step();
        mul_done = 1'b0;
        chk("idle_done_valid", resp_valid, 0);
        chk("idle_done_busy", busy, 0);
        step();
        chk("idle_done_valid2", resp_valid, 0);

        // Strobe in LAUNCH ignored; done on the last watchdog cycle still wins.
        req_valid = 4'b1000;
        do_job(TO, 1'b1, g);
        chk("coinc_err", resp_err, 0);
        req_valid = '0;

        // Reset while waiting drops the job.
        req_valid = 4'b0010;
        #1;
        chk("rst_grant", req_ready, 4'b0010);
        step();
        step();
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("midrst");
        model_last = N - 1;
        mul_done = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            mul_done = 1'b0;
            chk("midrst_no_resp", resp_valid, 0);
            chk("midrst_idle", busy, 0);
        end
        req_valid = 4'b1001;
        do_job(3, 1'b0, g);
        chk("midrst_grant", g, 0);

        // Random masks, operands and latencies.
        for (int j = 0; j < 40; j++) begin
            req_valid = 4'($urandom_range(1, 15));
            req_a = $urandom;
            req_b = $urandom;
            do_job(($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(1, 8)),
                   1'($urandom_range(0, 1)), g);
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_mul_scheduler.md
Name: booth_mul_scheduler

Overview:
- Round-robin scheduler that shares one signed Booth multiplier (WIDTH x WIDTH -> 2*WIDTH) between N_REQ requesters.
- Accepts one operand pair at a time and pulses the multiplier start.
- Waits for multiplier completion, with a watchdog timeout, then returns the product tagged with the requester index.
- Sits between the requesting datapath clients and the multiplier's control/datapath pair.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- WIDTH, 8, operand width in bits (signed two's complement)
- TIMEOUT, 64, max cycles spent in WAIT before the job is aborted with error (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester request; held high with operands stable until req_ready seen
- req_a  in  N_REQ*WIDTH  packed multiplicands; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  packed multipliers, same packing
- req_ready  out  N_REQ  one-hot, 1-cycle pulse: request accepted
- resp_valid  out  1  1-cycle pulse: result available
- resp_id  out  $clog2(N_REQ)  requester the result belongs to
- resp_prod  out  2*WIDTH  product; 0 when resp_err=1
- resp_err  out  1  watchdog timeout on this job
- busy  out  1  high in every state except IDLE
- mul_init  out  1  1-cycle start pulse to the multiplier
- mul_a  out  WIDTH  registered operand A to the multiplier
- mul_b  out  WIDTH  registered operand B to the multiplier
- mul_done  in  1  multiplier completion strobe
- mul_prod  in  2*WIDTH  multiplier product, valid when mul_done=1

Behaviour:
- Reset values:
  - All outputs 0: req_ready, resp_valid, resp_id, resp_prod, resp_err, busy, mul_init, mul_a, mul_b.
  - State=IDLE, timer=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- Reset mid-operation:
  - Next cycle is IDLE with the above values.
  - The in-flight job is dropped; no resp_valid is issued.
  - The multiplier shares rst and resets alongside.
- FSM states: IDLE, LAUNCH, WAIT, RESP. One-hot encoding.
- IDLE:
  - If any req_valid: grant g = first asserted index searching last+1, last+2, ... modulo N_REQ.
  - Assert req_ready[g] combinationally this cycle.
  - Register req_a/req_b slice g into mul_a/mul_b, register g.
  - Go to LAUNCH. Otherwise stay.
- LAUNCH:
  - mul_init=1 for exactly this cycle; clear timer.
  - Go to WAIT.
- WAIT:
  - mul_a/mul_b held stable (also stable during LAUNCH); timer increments each cycle.
  - If mul_done: capture mul_prod, resp_err=0, go to RESP.
  - Else if timer==TIMEOUT-1: capture product 0, resp_err=1, go to RESP.
  - mul_done has priority over timeout in the same cycle.
- RESP:
  - resp_valid=1 for one cycle, with resp_id=g and resp_prod/resp_err from the capture.
  - last<=g; go to IDLE.
  - resp_id/resp_prod/resp_err hold their value until the next RESP.
- Latency:
  - Accept at cycle t, mul_init at t+1.
  - mul_done at t+1+k (k>=1) gives resp_valid at t+2+k.
  - Next grant no earlier than t+3+k.
- Other rules:
  - mul_done outside WAIT is ignored.
  - Requests arriving in any state other than IDLE wait; req_ready is only ever asserted in IDLE.
  - No new job while busy; at most one outstanding job.
  - Deasserting req_valid before req_ready is allowed; that request simply is not granted.
- Timer width: $clog2(TIMEOUT)+1; no wrap-around is possible.

Test Plan:
- Only req0 with a=8'd3, b=8'hFB; model multiplier returns done after 10 cycles with 16'hFFF1.
  - -> req_ready=4'b0001 for 1 cycle, mul_init for 1 cycle the next cycle with mul_a=3, mul_b=FB.
  - -> resp_valid 1 cycle after done, resp_id=0, resp_prod=16'hFFF1, resp_err=0.
- All four req_valid held high continuously, each getting done after 5 cycles.
  - -> grant order 0,1,2,3,0,1.
  - -> each resp_id matches its grant; req_ready never asserted while busy=1.
- Timeout: grant req1, mul_done never asserted.
  - -> resp_valid exactly TIMEOUT cycles after entering WAIT, with resp_err=1, resp_prod=0, resp_id=1.
  - -> a subsequent req2 is then served normally.
- rst pulsed for one cycle while in WAIT.
  - -> next cycle all outputs 0, busy=0, no resp_valid for the dropped job.
  - -> then req0 and req3 together grants 0.
- After req1 served (last=1), req0 and req2 asserted together.
  - -> req2 granted first, then req0.
- mul_done pulsed in IDLE and in LAUNCH.
  - -> ignored; only a done during WAIT produces resp_valid.
  - -> mul_done coincident with timer==TIMEOUT-1 gives resp_err=0 with the real product.
